// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants and trigger qualification helper for gpio_intc
package gpio_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int DB_SAMPLES  = 3;
    localparam int ARM_CYCLES  = 3;
    localparam int ARM_W       = $clog2(ARM_CYCLES + 1);

    // Level mode matches pol; edge mode needs armed and a rise/fall (or either with both).
    function automatic logic trig_hit(
        input logic edge_mode,
        input logic pol,
        input logic both,
        input logic cur,
        input logic prev,
        input logic armed
    );
        logic rise;
        logic fall;
        logic hit;
        rise = cur & ~prev;
        fall = ~cur & prev;
        if (!edge_mode) begin
            hit = (cur == pol);
        end else if (both) begin
            hit = armed & (rise | fall);
        end else begin
            hit = armed & (pol ? rise : fall);
        end
        return hit;
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - per-pin synchronizer, debounce history and filtered level register
module gpio_in_filter
    import gpio_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_pin,
    input  logic i_tick,
    input  logic i_db_en,
    output logic o_filt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_SAMPLES-1:0]  r_hist;
    logic                   r_filt;
    logic                   w_sync;
    logic                   w_all_hi;
    logic                   w_all_lo;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_all_hi = &r_hist;
    assign w_all_lo = ~|r_hist;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync <= '0;
            r_hist <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            // History keeps shifting even while debounce is off, so enabling it is seamless.
            if (i_tick) begin
                r_hist <= {r_hist[DB_SAMPLES-2:0], w_sync};
            end
            if (!i_db_en) begin
                r_filt <= w_sync;
            end else if (w_all_hi) begin
                r_filt <= 1'b1;
            end else if (w_all_lo) begin
                r_filt <= 1'b0;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/gpio_intc.sv
// rtl/gpio_intc.sv - GPIO input interrupt controller: filtering, trigger qualification, pending, irq
module gpio_intc
    import gpio_pkg::*;
#(
    parameter int GPIO_PORT_NUM = 32,
    parameter int DB_DIV_W      = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [GPIO_PORT_NUM-1:0] gpio_pin_in,
    input  logic [GPIO_PORT_NUM-1:0] ctrl_int_en,
    input  logic [GPIO_PORT_NUM-1:0] ctrl_edge_sel,
    input  logic [GPIO_PORT_NUM-1:0] ctrl_pol_sel,
    input  logic [GPIO_PORT_NUM-1:0] ctrl_both_sel,
    input  logic [GPIO_PORT_NUM-1:0] ctrl_db_en,
    input  logic [DB_DIV_W-1:0]      db_div,
    input  logic [GPIO_PORT_NUM-1:0] pend_clr,
    output logic [GPIO_PORT_NUM-1:0] pend_status,
    output logic [GPIO_PORT_NUM-1:0] gpio_filtered,
    output logic                     irq
);

    logic [DB_DIV_W-1:0]      r_cnt;
    logic [ARM_W-1:0]         r_arm;
    logic                     r_armed;
    logic [GPIO_PORT_NUM-1:0] r_prev;
    logic [GPIO_PORT_NUM-1:0] r_pend;
    logic                     r_irq;
    logic                     w_tick;
    logic [GPIO_PORT_NUM-1:0] w_filt;
    logic [GPIO_PORT_NUM-1:0] w_event;
    logic [GPIO_PORT_NUM-1:0] w_set;

    // ">=" rather than "==" so a divisor lowered below the count wraps on the next cycle.
    assign w_tick = (r_cnt >= db_div);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < GPIO_PORT_NUM; g++) begin : g_pin
        gpio_in_filter u_filter (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .i_pin     (gpio_pin_in[g]),
            .i_tick    (w_tick),
            .i_db_en   (ctrl_db_en[g]),
            .o_filt    (w_filt[g])
        );
    end

    // The filtered register sits one stage behind the synchronizer, so the first
    // post-reset mismatch reaches the edge compare just as the counter saturates.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_arm   <= '0;
            r_armed <= 1'b0;
        end else begin
            if (r_arm != ARM_W'(ARM_CYCLES)) begin
                r_arm <= r_arm + 1'b1;
            end
            r_armed <= (r_arm == ARM_W'(ARM_CYCLES));
        end
    end

    always_comb begin
        w_event = '0;
        for (int i = 0; i < GPIO_PORT_NUM; i++) begin
            w_event[i] = trig_hit(ctrl_edge_sel[i], ctrl_pol_sel[i], ctrl_both_sel[i],
                                  w_filt[i], r_prev[i], r_armed);
        end
    end

    assign w_set = ctrl_int_en & w_event;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_prev <= '0;
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= w_filt;
            r_pend <= (r_pend & ~pend_clr) | w_set;
            r_irq  <= |r_pend;
        end
    end

    assign pend_status   = r_pend;
    assign gpio_filtered = w_filt;
    assign irq           = r_irq;

endmodule
